// File: rtl/button_conditioner.sv
// Stopwatch input stage: synchronises and debounces three pushbuttons and the countdown switch.
// Buttons become single-cycle press pulses; the switch becomes a clean level.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_clear,
  input  logic sw_countdown,
  output logic Start,
  output logic Stop,
  output logic Clear,
  output logic Countdown
);

  localparam int NCH = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Channel order: 0 start, 1 stop, 2 clear, 3 countdown switch.
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   q1;
  logic [NCH-1:0]   q2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   accept;
  logic [NCH-1:0]   rise;
  logic [CNT_W-1:0] cnt [NCH];

  assign raw = {sw_countdown, btn_clear, btn_stop, btn_start};

  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i] = (q2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      rise[i]   = accept[i] && q2[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1     <= '0;
      q2     <= '0;
      stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      Start  <= 1'b0;
      Stop   <= 1'b0;
      Clear  <= 1'b0;
    end else begin
      q1 <= raw;
      q2 <= q1;
      for (int i = 0; i < NCH; i++) begin
        if (q2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= q2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
      // Conflicting presses in one cycle: Clear wins, Start+Stop cancel; losers are dropped.
      Start <= rise[0] && !rise[1] && !rise[2];
      Stop  <= rise[1] && !rise[0] && !rise[2];
      Clear <= rise[2];
    end
  end

  assign Countdown = stable[3];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: per-cycle expected outputs are queued by the driver
// and compared by a monitor sampling 1 time unit after each rising edge.
module tb_button_conditioner;

  logic clk;
  logic reset;
  logic btn_start, btn_stop, btn_clear, sw_countdown;
  logic Start, Stop, Clear, Countdown;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  string phase    = "init";

  logic [3:0] exp_q[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_stop    (btn_stop),
    .btn_clear   (btn_clear),
    .sw_countdown(sw_countdown),
    .Start       (Start),
    .Stop        (Stop),
    .Clear       (Clear),
    .Countdown   (Countdown)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b ({Countdown,Clear,Stop,Start})", tag, got, exp);
    end
  endtask

  // raw = {sw_countdown, btn_clear, btn_stop, btn_start}; pulse = {Clear, Stop, Start}.
  // Inputs change at the negedge before window edge 1; pulse_edge/cd_edge are 1-based (0 = never).
  task automatic window(input int n, input logic [3:0] raw, input logic rst,
                        input int pulse_edge, input logic [2:0] pulse,
                        input logic cd0, input int cd_edge, input logic cd1);
    logic [3:0] e;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      reset        = rst;
      btn_start    = raw[0];
      btn_stop     = raw[1];
      btn_clear    = raw[2];
      sw_countdown = raw[3];
      e[3]   = (cd_edge != 0 && j >= cd_edge) ? cd1 : cd0;
      e[2:0] = (j == pulse_edge) ? pulse : 3'b000;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input logic cd);
    window(8 + $urandom_range(0, 4), {cd, 3'b000}, 1'b1, 0, 3'b000, cd, 0, cd);
  endtask

  // scoreboard monitor
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s@%0d", phase, cyc), {Countdown, Clear, Stop, Start}, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    {btn_start, btn_stop, btn_clear, sw_countdown} = '0;

    phase = "reset_hold";
    window(3, 4'b1111, 1'b0, 0, 3'b000, 1'b0, 0, 1'b0);
    phase = "start_thru_reset";
    window(12, 4'b0001, 1'b1, 6, 3'b001, 1'b0, 0, 1'b0);
    phase = "start_release";
    idle(1'b0);

    phase = "stop_bounce";
    window(2, 4'b0010, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    window(1, 4'b0000, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    window(3, 4'b0010, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    window(2, 4'b0000, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    phase = "stop_settled";
    window(10 + $urandom_range(0, 3), 4'b0010, 1'b1, 6, 3'b010, 1'b0, 0, 1'b0);
    phase = "stop_release";
    idle(1'b0);
    phase = "stop_repress";
    window(10, 4'b0010, 1'b1, 6, 3'b010, 1'b0, 0, 1'b0);
    phase = "stop_release2";
    idle(1'b0);

    phase = "start_clear";
    window(10, 4'b0101, 1'b1, 6, 3'b100, 1'b0, 0, 1'b0);
    idle(1'b0);
    phase = "start_stop";
    window(10, 4'b0011, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    idle(1'b0);

    phase = "cd_rise";
    window(10, 4'b1000, 1'b1, 0, 3'b000, 1'b0, 6, 1'b1);
    phase = "cd_glitch";
    window(3, 4'b0000, 1'b1, 0, 3'b000, 1'b1, 0, 1'b1);
    window(8, 4'b1000, 1'b1, 0, 3'b000, 1'b1, 0, 1'b1);
    phase = "cd_with_button";
    window(10, 4'b1001, 1'b1, 6, 3'b001, 1'b1, 0, 1'b1);
    idle(1'b1);
    phase = "cd_fall";
    window(10, 4'b0000, 1'b1, 0, 3'b000, 1'b1, 6, 1'b0);

    phase = "clear_mid_reset";
    window(4, 4'b0100, 1'b1, 0, 3'b000, 1'b0, 0, 1'b0);
    window(2, 4'b0100, 1'b0, 0, 3'b000, 1'b0, 0, 1'b0);
    phase = "clear_after_reset";
    window(10, 4'b0100, 1'b1, 6, 3'b100, 1'b0, 0, 1'b0);
    phase = "final_idle";
    idle(1'b0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    check("drain", {3'b000, exp_q.size() != 0}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
